muldiv_hilo: RTL and testbench

MULDIV_HILO -- requirements
Module: muldiv_hilo

---
 rtl/muldiv_hilo.sv | 172 +++++++++++++++++
 tb/tb_muldiv_hilo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// +--------------------------------------------------------------------------+
// | muldiv_hilo : iterative 32x32 MULT/DIV unit with HI/LO result registers  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module muldiv_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] wh_q, wh_d;      // product high / partial remainder
  logic [31:0] wl_q, wl_d;      // multiplier / dividend-quotient shifter
  logic [31:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic        is_div_q, is_div_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        w_sgn;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_sum;
  logic [32:0] w_rsh;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;

  assign w_sgn   = ~op[0];
  assign w_mag_a = (w_sgn && a[31]) ? (32'd0 - a) : a;
  assign w_mag_b = (w_sgn && b[31]) ? (32'd0 - b) : b;

  assign w_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opnd_q} : 33'd0);

  // Remainder is always below the divisor, so a 32-bit difference suffices.
  assign w_rsh   = {wh_q, wl_q[31]};
  assign w_ge    = (w_rsh >= {1'b0, opnd_q});
  assign w_diff  = w_rsh[31:0] - opnd_q;

  assign w_prod   = {wh_q, wl_q};
  assign w_prod_s = neg_q_q ? (64'd0 - w_prod) : w_prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wh_d     = wh_q;
    wl_d     = wl_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d  = S_CALC;
              cnt_d    = 5'd31;
              is_div_d = 1'b0;
              opnd_d   = w_mag_a;
              wl_d     = w_mag_b;
              wh_d     = 32'd0;
              neg_q_d  = w_sgn && (a[31] ^ b[31]);
              neg_r_d  = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              state_d  = S_CALC;
              cnt_d    = 5'd31;
              is_div_d = 1'b1;
              opnd_d   = w_mag_b;
              wl_d     = w_mag_a;
              wh_d     = 32'd0;
              // Divide by zero keeps the all-ones quotient unsigned.
              neg_q_d  = w_sgn && (a[31] ^ b[31]) && (b != 32'd0);
              neg_r_d  = w_sgn && a[31];
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          wh_d = w_ge ? w_diff : w_rsh[31:0];
          wl_d = {wl_q[30:0], w_ge};
        end else begin
          wh_d = w_sum[32:1];
          wl_d = {w_sum[0], wl_q[31:1]};
        end
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_div_q) begin
          lo_d = neg_q_q ? (32'd0 - wl_q) : wl_q;
          hi_d = neg_r_q ? (32'd0 - wh_q) : wh_q;
        end else begin
          hi_d = w_prod_s[63:32];
          lo_d = w_prod_s[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      wh_q     <= 32'd0;
      wl_q     <= 32'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wh_q     <= wh_d;
      wl_q     <= wl_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == S_CALC) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
// +--------------------------------------------------------------------------+
// | tb_muldiv_hilo : scoreboard bench for the muldiv_hilo HI/LO unit         |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;
  logic [31:0] sp[6] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF,
                         32'h7FFF_FFFF, 32'hFFFF_FFFE};

  always #5 clk = ~clk;

  muldiv_hilo dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} computed with wide integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, res;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    res = 64'd0;
    case (o)
      3'd0: res = sx * sy;
      3'd1: res = ux * uy;
      3'd2: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else res = {32'(x % y), 32'(x / y)};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Drives one request across the accept edge; returns 1 time unit after it.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (o <= 3'd3) sb_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    if (o == 3'd4) mdl_hi = x;
    if (o == 3'd5) mdl_lo = x;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_result(input int inject);
    int          lat = 0;
    logic        ok  = 1'b1;
    logic [63:0] exp;
    while (!done && lat < 40) begin
      if (!busy || hi !== mdl_hi || lo !== mdl_lo) ok = 1'b0;
      if (lat == inject) begin
        start = 1'b1;
        op    = 3'd4;
        a     = 32'hDEAD_BEEF;
      end
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
    end
    check("busy_hold", {63'd0, ok}, 64'd1);
    check("latency", 64'(lat), 64'd33);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check("hi", {32'd0, hi}, {32'd0, exp[63:32]});
      check("lo", {32'd0, lo}, {32'd0, exp[31:0]});
      mdl_hi = exp[63:32];
      mdl_lo = exp[31:0];
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    #23;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_flags", {62'd0, busy, done}, 64'd0);

    // Accept on the very first edge after release.
    @(negedge clk);
    reset = 1'b1;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result(-1);
    check("multu_max", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    @(posedge clk);
    #1;
    check("done_pulse", {62'd0, busy, done}, 64'd0);

    issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_result(-1);
    check("mult_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_result(-1);
    check("div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(3'd3, 32'h0000_0064, 32'h0);
    wait_result(-1);
    check("divu_zero", {hi, lo}, {32'h0000_0064, 32'hFFFF_FFFF});
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result(-1);
    check("div_ovf", {hi, lo}, {32'h0000_0000, 32'h8000_0000});
    issue(3'd2, 32'hFFFF_FF00, 32'h0);
    wait_result(-1);
    check("div_zero_neg", {hi, lo}, {32'hFFFF_FF00, 32'hFFFF_FFFF});

    issue(3'd4, 32'h1234_5678, 32'h0);
    check("mthi_flags", {62'd0, busy, done}, 64'd0);
    issue(3'd5, 32'h9ABC_DEF0, 32'h0);
    check("mtlo_flags", {62'd0, busy, done}, 64'd0);
    check("mthi_mtlo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});

    issue(3'd6, 32'h5555_5555, 32'h1);
    check("nop_hilo", {hi, lo}, {mdl_hi, mdl_lo});
    check("nop_flags", {62'd0, busy, done}, 64'd0);

    // MTHI during CALC must be dropped; then a back-to-back accept from DONE.
    issue(3'd1, 32'd3, 32'd5);
    wait_result(9);
    check("multu_3x5", {hi, lo}, {32'h0, 32'h0000_000F});
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b_flags", {62'd0, busy, done}, 64'd2);
    wait_result(-1);

    issue(3'd3, 32'd100, 32'd7);
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_flags", {62'd0, busy, done}, 64'd0);
    sb_q.delete();
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst", {busy, done, hi, lo}, 64'd0);
    issue(3'd3, 32'd100, 32'd7);
    wait_result(-1);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});

    for (int i = 0; i < 20; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
      issue(ro, ra, rb);
      wait_result(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
